ads8688_autoscan: RTL and testbench
===================================

Name: ads8688_autoscan

Overview:
- Parametrised successor to the single-channel ADS8688 manual-select controller.
- Scans a run-time channel mask of up to NUM_CH inputs in one or continuous passes.
- Issues ADS8688 MAN_Ch_n commands back-to-back and absorbs the device's one-frame result latency (frame k returns the conversion commanded in frame k-1).
- Tags each result with its channel and delivers it on a valid/ready stream to the acquisition buffer.

Parameters:
- NUM_CH, 8, number of ADC inputs scanned (1..8).
- CLK_DIV, 5, half-period of SCLK in clk cycles (SCLK = f_clk/(2*CLK_DIV)); minimum 2.
- CSN_GAP, 4, clk cycles csn is held high between frames; minimum 1.
- DATA_W, 16, ADC result width.
- FRAME_W, 32, SCLK cycles per frame: 16 command bits, then 16 data bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- scan_start  in  1  one-cycle pulse; starts a pass when idle, ignored otherwise.
- continuous  in  1  when 1, a new pass starts immediately after each pass completes.
- ch_mask  in  NUM_CH  enabled channels; sampled at scan_start and at each pass start.
- sclk  out  1  SPI clock, CPOL=0.
- csn  out  1  chip select, active low.
- mosi  out  1  command bit, MSB first; changes on SCLK falling edge.
- miso  in  1  sampled on SCLK rising edge.
- busy  out  1  high from accepted start until the pass ends.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result when out_valid & out_ready.
- out_ch  out  $clog2(NUM_CH) (min 1)  channel of the result.
- out_data  out  DATA_W  conversion result (frame bits 15..0).
- scan_done  out  1  one-cycle pulse, coincident with the cycle in which the last result of a pass is accepted.

Behaviour:
- Reset: sclk=0, csn=1, mosi=0, busy=0, out_valid=0, out_ch=0, out_data=0, scan_done=0; FSM goes to IDLE.
- Reset asserted mid-frame aborts the frame at once (csn=1 next cycle); the pending result is discarded.
- Command encoding: MAN_Ch_n = 16'hC000 | (n<<10), giving C000, C400, ... DC00. NO_OP = 16'h0000.
- Pass start:
  - Latch ch_mask. If the latched mask is all-zero, the pass completes immediately: busy pulses for 1 cycle, scan_done pulses, no frame is sent.
  - Build the list of enabled channels in ascending index.
- Frame sequence for E enabled channels: E+1 frames.
  - Frame 0 sends MAN_Ch of the first channel; its received data is discarded.
  - Frame i (1..E-1) sends MAN_Ch of channel i and returns data for channel i-1.
  - Frame E sends NO_OP and returns data for the last channel.
- FSM states:
  - IDLE -> LOAD on scan_start.
  - LOAD (1 cycle; latch mask, select first channel) -> FRAME.
  - FRAME: csn=0 for exactly FRAME_W*2*CLK_DIV cycles; sclk starts low, first rising edge occurs CLK_DIV cycles after csn falls. -> GAP.
  - GAP: csn=1 for CSN_GAP cycles, result pushed to the output register. -> HOLD if out_valid & ~out_ready; else FRAME (more frames remain), LOAD (continuous=1), or IDLE.
  - HOLD: waits for the handshake, then continues as from GAP.
- Back-pressure: a new frame never starts while out_valid is high and unaccepted. No result is ever dropped or overwritten.
- out_valid rises the cycle after GAP is entered and falls the cycle after the handshake. out_ch/out_data are stable while out_valid=1.
- busy deasserts in the cycle the final handshake completes (non-continuous). In continuous mode busy stays 1; deasserting continuous ends after the current pass.
- scan_start while busy: ignored. ch_mask changes mid-pass: no effect until the next pass start.

Decomposition:
- Package ads8688_pkg holds:
  - MAN_CH_BASE (16'hC000), MAN_CH_SHIFT (10), NO_OP (16'h0000).
  - FSM state enum {IDLE, LOAD, FRAME, GAP, HOLD}.
  - A function returning the next enabled channel index from a mask and the current index.
- One sub-module, ads8688_frame_shifter, owns the per-frame SPI timing:
  - Inputs: start, 16-bit command.
  - Outputs: sclk, csn, mosi, done, 16-bit rx data (CLK_DIV, FRAME_W).
  - The top keeps the scan FSM, channel tracking and output register.

Test Plan:
- Single pass, mask=8'b0000_0101, out_ready=1, device model returns 16'hA000+ch:
  - mosi frames = C000, C800, 0000.
  - Outputs (ch0, A000) then (ch2, A002); scan_done pulses once; busy falls with it.
- Mask=8'h00 with scan_start -> no csn activity; scan_done pulse 1–2 cycles after start.
- Back-pressure, mask=8'hFF, out_ready low for 100 cycles after first out_valid:
  - Next csn falling edge is delayed until the handshake.
  - All 8 results arrive in order ch0..ch7 with correct data.
- Continuous=1, mask=8'b1000_0001 for 3 passes, continuous dropped during pass 3:
  - Results ch0, ch7 repeated 3 times; 3 scan_done pulses; IDLE after pass 3.
- rst pulsed mid-frame 2 of an 8-channel pass:
  - csn=1 and out_valid=0 the next cycle; no further frames.
  - A new scan_start restarts cleanly at ch0.
- Timing check, CLK_DIV=5, CSN_GAP=4:
  - Frame length 320 clk; SCLK period 10 clk; first rising edge 5 clk after csn falls.
  - csn high gap of at least 4 clk between frames.

Source files
------------

// File: rtl/ads8688_pkg.sv
// Shared constants, scan FSM states and channel-walk helper
// for the ADS8688 auto-scan controller.
package ads8688_pkg;

   localparam logic [15:0] MAN_CH_BASE  = 16'hC000;
   localparam int          MAN_CH_SHIFT = 10;
   localparam logic [15:0] NO_OP        = 16'h0000;
   localparam int          MAX_CH       = 8;
   localparam logic [3:0]  CH_NONE      = 4'd8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      FRAME = 3'd2,
      GAP   = 3'd3,
      HOLD  = 3'd4
   } state_t;

   // Lowest enabled channel at or above 'from'; CH_NONE if none.
   function automatic logic [3:0] next_ch(
      input logic [MAX_CH-1:0] mask,
      input logic [3:0]        from
   );
      next_ch = CH_NONE;
      for (int i = MAX_CH - 1; i >= 0; i--) begin
         if (mask[i] && (4'(i) >= from)) next_ch = 4'(i);
      end
   endfunction

endpackage

// File: rtl/ads8688_frame_shifter.sv
// One 16-bit-command / 16-bit-data SPI frame, CPOL=0:
// mosi moves on SCLK fall, miso captured on SCLK rise.
module ads8688_frame_shifter #(
   parameter int CLK_DIV = 5,
   parameter int FRAME_W = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] cmd,
   input  logic        miso,
   output logic        sclk,
   output logic        csn,
   output logic        mosi,
   output logic        done,
   output logic [15:0] rx_data
);

   localparam int DW    = $clog2(CLK_DIV);
   localparam int HW    = $clog2(2 * FRAME_W);
   localparam int HLAST = 2 * FRAME_W - 1;

   logic          active;
   logic [DW-1:0] div;
   logic [HW-1:0] half;
   logic [15:0]   tx;

   always_ff @(posedge clk) begin
      if (rst) begin
         active  <= 1'b0;
         div     <= '0;
         half    <= '0;
         tx      <= '0;
         rx_data <= '0;
         sclk    <= 1'b0;
         csn     <= 1'b1;
         mosi    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!active) begin
            if (start) begin
               active <= 1'b1;
               csn    <= 1'b0;
               sclk   <= 1'b0;
               div    <= '0;
               half   <= '0;
               mosi   <= cmd[15];
               tx     <= {cmd[14:0], 1'b0};
            end
         end else if (div != DW'(CLK_DIV - 1)) begin
            div <= div + 1'b1;
         end else begin
            div <= '0;
            if (half == HW'(HLAST)) begin
               active <= 1'b0;
               csn    <= 1'b1;
               sclk   <= 1'b0;
               mosi   <= 1'b0;
               done   <= 1'b1;
            end else begin
               half <= half + 1'b1;
               sclk <= ~sclk;
               // Low-to-high: capture; high-to-low: next command bit
               if (!sclk) begin
                  rx_data <= {rx_data[14:0], miso};
               end else begin
                  mosi <= tx[15];
                  tx   <= {tx[14:0], 1'b0};
               end
            end
         end
      end
   end

endmodule

// File: rtl/ads8688_autoscan.sv
// Masked multi-channel ADS8688 scanner: pipelines MAN_Ch commands
// across frames and streams channel-tagged results.
module ads8688_autoscan
   import ads8688_pkg::*;
#(
   parameter  int NUM_CH  = 8,
   parameter  int CLK_DIV = 5,
   parameter  int CSN_GAP = 4,
   parameter  int DATA_W  = 16,
   parameter  int FRAME_W = 32,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scan_start,
   input  logic              continuous,
   input  logic [NUM_CH-1:0] ch_mask,
   output logic              sclk,
   output logic              csn,
   output logic              mosi,
   input  logic              miso,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CH_W-1:0]   out_ch,
   output logic [DATA_W-1:0] out_data,
   output logic              scan_done
);

   localparam int GAP_LAST = (CSN_GAP < 2) ? 1 : CSN_GAP - 1;
   localparam int GW       = $clog2(GAP_LAST + 1);

   state_t              state;
   logic [MAX_CH-1:0]   mask_in;
   logic [MAX_CH-1:0]   mask_q;
   logic [3:0]          cmd_ch;
   logic [3:0]          nxt;
   logic [3:0]          first;
   logic [CH_W-1:0]     prev_ch;
   logic                cmd_live;
   logic                prev_live;
   logic                more;
   logic                fs_start;
   logic                fs_done;
   logic                busy_r;
   logic                cont_q;
   logic                empty_done;
   logic                out_last;
   logic [GW-1:0]       gap_cnt;
   logic [15:0]         cmd;
   logic [15:0]         rx;
   logic                hs;
   logic                fin_hs;
   logic                can_go;
   logic                cont_eff;
   logic                leave;

   always_comb begin
      mask_in             = '0;
      mask_in[NUM_CH-1:0] = ch_mask;
   end

   assign first    = next_ch(mask_in, 4'd0);
   assign nxt      = next_ch(mask_q, cmd_ch + 4'd1);
   assign cmd      = cmd_live
                   ? (MAN_CH_BASE | (16'(cmd_ch) << MAN_CH_SHIFT))
                   : NO_OP;
   assign hs       = out_valid & out_ready;
   assign fin_hs   = hs & out_last;
   assign can_go   = ~out_valid | out_ready;
   assign cont_eff = fin_hs ? continuous : cont_q;
   assign leave    = can_go & ((state == HOLD) ||
                     (state == GAP && gap_cnt == GW'(GAP_LAST)));
   assign scan_done = fin_hs | empty_done;
   assign busy      = busy_r & ~(fin_hs & ~continuous);

   ads8688_frame_shifter #(
      .CLK_DIV (CLK_DIV),
      .FRAME_W (FRAME_W)
   ) u_shift (
      .clk     (clk),
      .rst     (rst),
      .start   (fs_start),
      .cmd     (cmd),
      .miso    (miso),
      .sclk    (sclk),
      .csn     (csn),
      .mosi    (mosi),
      .done    (fs_done),
      .rx_data (rx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mask_q     <= '0;
         cmd_ch     <= '0;
         prev_ch    <= '0;
         cmd_live   <= 1'b0;
         prev_live  <= 1'b0;
         more       <= 1'b0;
         fs_start   <= 1'b0;
         busy_r     <= 1'b0;
         cont_q     <= 1'b0;
         empty_done <= 1'b0;
         out_last   <= 1'b0;
         gap_cnt    <= '0;
         out_valid  <= 1'b0;
         out_ch     <= '0;
         out_data   <= '0;
      end else begin
         fs_start   <= 1'b0;
         empty_done <= 1'b0;
         if (hs) out_valid <= 1'b0;
         if (fin_hs) begin
            cont_q <= continuous;
            busy_r <= continuous;
         end
         unique case (state)
            IDLE: begin
               if (scan_start) begin
                  busy_r <= 1'b1;
                  state  <= LOAD;
               end
            end
            LOAD: begin
               mask_q    <= mask_in;
               cmd_ch    <= first;
               cmd_live  <= 1'b1;
               prev_live <= 1'b0;
               if (first == CH_NONE) begin
                  empty_done <= 1'b1;
                  busy_r     <= continuous;
                  state      <= continuous ? LOAD : IDLE;
               end else begin
                  fs_start <= 1'b1;
                  state    <= FRAME;
               end
            end
            FRAME: begin
               if (fs_done) begin
                  gap_cnt <= '0;
                  state   <= GAP;
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt + 1'b1;
               // The frame just ended answers the previous command
               if (gap_cnt == '0) begin
                  if (prev_live) begin
                     out_valid <= 1'b1;
                     out_ch    <= prev_ch;
                     out_data  <= rx[DATA_W-1:0];
                     out_last  <= ~cmd_live;
                  end
                  prev_ch   <= cmd_ch[CH_W-1:0];
                  prev_live <= cmd_live;
                  more      <= cmd_live;
                  cmd_live  <= cmd_live & (nxt != CH_NONE);
                  cmd_ch    <= nxt;
               end
               if (gap_cnt == GW'(GAP_LAST) && !can_go) state <= HOLD;
            end
            HOLD: ;
            default: state <= IDLE;
         endcase
         if (leave) begin
            if (more) begin
               fs_start <= 1'b1;
               state    <= FRAME;
            end else if (cont_eff) begin
               state <= LOAD;
            end else begin
               busy_r <= 1'b0;
               state  <= IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_ads8688_autoscan.sv
// Bench for ads8688_autoscan: ADS8688 device model, list-based
// reference model, table-driven and randomized scans.
module tb_ads8688_autoscan;

   logic        clk = 1'b0;
   logic        rst;
   logic        scan_start;
   logic        continuous;
   logic [7:0]  ch_mask;
   logic        sclk;
   logic        csn;
   logic        mosi;
   logic        miso;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  out_ch;
   logic [15:0] out_data;
   logic        scan_done;

   ads8688_autoscan #(
      .NUM_CH  (8),
      .CLK_DIV (5),
      .CSN_GAP (4),
      .DATA_W  (16),
      .FRAME_W (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .scan_start (scan_start),
      .continuous (continuous),
      .ch_mask    (ch_mask),
      .sclk       (sclk),
      .csn        (csn),
      .mosi       (mosi),
      .miso       (miso),
      .busy       (busy),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_ch     (out_ch),
      .out_data   (out_data),
      .scan_done  (scan_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] mask;
      int         n_res;
      int         first_ch;
      int         last_ch;
   } vec_t;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int st_cyc   = 0;
   int frames   = 0;
   bit rand_ready = 1'b0;

   logic [15:0] dev_val [8];
   logic [15:0] cmd_q   [$];
   logic [18:0] got_q   [$];
   logic [15:0] exp_cmd [$];
   logic [18:0] exp_res [$];

   logic        pv = 1'b0;
   logic        pr = 1'b0;
   logic [2:0]  pch;
   logic [15:0] pdata;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(posedge clk) cyc++;
   always @(negedge csn) frames++;

   // Device: frame k answers the MAN_Ch command of frame k-1
   initial begin
      logic [15:0] rcmd;
      logic [15:0] resp;
      int nb;
      miso = 1'b0;
      resp = 16'hDEAD;
      forever begin
         @(negedge csn);
         nb   = 0;
         rcmd = '0;
         miso = 1'b0;
         while (nb < 32) begin
            @(posedge sclk or posedge csn);
            if (csn) break;
            if (nb < 16) rcmd = {rcmd[14:0], mosi};
            nb++;
            if (nb < 32) begin
               @(negedge sclk or posedge csn);
               if (csn) break;
               miso = (nb < 16) ? 1'b0 : resp[31 - nb];
            end
         end
         if (nb == 32) begin
            cmd_q.push_back(rcmd);
            resp = (rcmd[15:13] == 3'b110) ? dev_val[rcmd[12:10]]
                                           : 16'hDEAD;
            if (!csn) @(posedge csn);
         end else begin
            resp = 16'hDEAD;
         end
         miso = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         pv = 1'b0;
      end else begin
         if (pv && !pr) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_ch", 32'(out_ch), 32'(pch));
            chk("hold_data", 32'(out_data), 32'(pdata));
         end
         if (out_valid && out_ready) got_q.push_back({out_ch, out_data});
         if (scan_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (!continuous) chk("busy_with_done", 32'(busy), 32'd0);
         end
         pv    = out_valid;
         pr    = out_ready;
         pch   = out_ch;
         pdata = out_data;
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic clear_q();
      cmd_q.delete();
      got_q.delete();
      exp_cmd.delete();
      exp_res.delete();
   endtask

   // Reference: enabled channels ascending, then one NO_OP frame
   task automatic build_exp(input logic [7:0] m);
      for (int ch = 0; ch < 8; ch++) begin
         if (m[ch]) begin
            exp_cmd.push_back(16'hC000 + 16'(ch * 1024));
            exp_res.push_back({3'(ch), dev_val[ch]});
         end
      end
      if (m != 8'h00) exp_cmd.push_back(16'h0000);
   endtask

   task automatic compare_all(input string nm);
      chk({nm, "_ncmd"}, 32'(cmd_q.size()), 32'(exp_cmd.size()));
      for (int i = 0; i < exp_cmd.size() && i < cmd_q.size(); i++)
         chk({nm, "_cmd"}, 32'(cmd_q[i]), 32'(exp_cmd[i]));
      chk({nm, "_nres"}, 32'(got_q.size()), 32'(exp_res.size()));
      for (int i = 0; i < exp_res.size() && i < got_q.size(); i++)
         chk({nm, "_res"}, 32'(got_q[i]), 32'(exp_res[i]));
   endtask

   task automatic pulse_start(input logic [7:0] m);
      ch_mask    = m;
      scan_start = 1'b1;
      st_cyc     = cyc;
      tick(1);
      scan_start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string nm);
      int t = 0;
      while (done_cnt <= d0 && t < 20000) begin
         tick(1);
         t++;
      end
      chk({nm, "_timeout"}, 32'(t < 20000), 32'd1);
   endtask

   task automatic run_pass(input logic [7:0] m, input string nm);
      int d0 = done_cnt;
      pulse_start(m);
      wait_done(d0, nm);
      tick(10);
      chk({nm, "_ndone"}, 32'(done_cnt - d0), 32'd1);
      chk({nm, "_busy_end"}, 32'(busy), 32'd0);
   endtask

   vec_t tbl [6];

   initial begin
      int d0, f0, f1, t, r1;
      logic [7:0] m;
      tbl[0] = '{8'h05, 2, 0, 2};
      tbl[1] = '{8'h80, 1, 7, 7};
      tbl[2] = '{8'hFF, 8, 0, 7};
      tbl[3] = '{8'h01, 1, 0, 0};
      tbl[4] = '{8'h5A, 4, 1, 6};
      tbl[5] = '{8'h00, 0, 0, 0};
      for (int i = 0; i < 8; i++) dev_val[i] = 16'hA000 + 16'(i);
      rst = 1'b1; scan_start = 1'b0; continuous = 1'b0;
      ch_mask = 8'h00; out_ready = 1'b1;
      tick(3);
      @(negedge clk);
      chk("rst_sclk", 32'(sclk), 32'd0);
      chk("rst_csn", 32'(csn), 32'd1);
      chk("rst_mosi", 32'(mosi), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_ch", 32'(out_ch), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_done", 32'(scan_done), 32'd0);
      tick(1);
      rst = 1'b0;
      tick(2);

      // SPI timing on a single-channel pass
      clear_q();
      build_exp(8'h01);
      d0 = done_cnt;
      pulse_start(8'h01);
      t = 0;
      while (csn && t < 100) begin tick(1); t++; end
      chk("tm_csn_fall", 32'(csn), 32'd0);
      f0 = cyc;
      t = 0;
      while (!sclk && t < 100) begin tick(1); t++; end
      chk("tm_first_rise", 32'(cyc - f0), 32'd5);
      r1 = cyc;
      t = 0;
      while (sclk && t < 100) begin tick(1); t++; end
      while (!sclk && t < 100) begin tick(1); t++; end
      chk("tm_period", 32'(cyc - r1), 32'd10);
      t = 0;
      while (!csn && t < 1000) begin tick(1); t++; end
      chk("tm_frame_len", 32'(cyc - f0), 32'd320);
      r1 = cyc;
      t = 0;
      while (csn && t < 100) begin tick(1); t++; end
      chk("tm_gap_min", 32'((cyc - r1) >= 4), 32'd1);
      wait_done(d0, "tm");
      tick(10);
      compare_all("tm");

      foreach (tbl[i]) begin
         clear_q();
         build_exp(tbl[i].mask);
         f0 = frames;
         run_pass(tbl[i].mask, "tbl");
         compare_all("tbl");
         chk("tbl_count", 32'(got_q.size()), 32'(tbl[i].n_res));
         if (tbl[i].n_res > 0 && got_q.size() > 0) begin
            chk("tbl_first", 32'(got_q[0][18:16]), 32'(tbl[i].first_ch));
            chk("tbl_last", 32'(got_q[got_q.size()-1][18:16]),
                32'(tbl[i].last_ch));
         end
         if (tbl[i].mask == 8'h00) begin
            chk("empty_frames", 32'(frames - f0), 32'd0);
            chk("empty_delay", 32'((done_cyc - st_cyc) >= 1 &&
                                   (done_cyc - st_cyc) <= 2), 32'd1);
         end
      end

      // Back-pressure holds the next frame until the handshake
      clear_q();
      build_exp(8'hFF);
      out_ready = 1'b0;
      d0 = done_cnt;
      pulse_start(8'hFF);
      t = 0;
      while (!out_valid && t < 5000) begin tick(1); t++; end
      chk("bp_valid", 32'(out_valid), 32'd1);
      f0 = frames;
      tick(100);
      chk("bp_no_frame", 32'(frames), 32'(f0));
      chk("bp_csn_high", 32'(csn), 32'd1);
      chk("bp_still_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      wait_done(d0, "bp");
      tick(10);
      compare_all("bp");

      // Continuous: three passes, continuous dropped in the third
      clear_q();
      for (int p = 0; p < 3; p++) build_exp(8'h81);
      continuous = 1'b1;
      d0 = done_cnt;
      pulse_start(8'h81);
      t = 0;
      while (done_cnt < d0 + 2 && t < 20000) begin tick(1); t++; end
      chk("cont_two_passes", 32'(done_cnt - d0), 32'd2);
      tick(400);
      continuous = 1'b0;
      wait_done(d0 + 2, "cont");
      tick(700);
      chk("cont_ndone", 32'(done_cnt - d0), 32'd3);
      chk("cont_idle", 32'(busy), 32'd0);
      compare_all("cont");

      // Reset during the third frame of an eight-channel pass
      clear_q();
      f0 = frames;
      pulse_start(8'hFF);
      t = 0;
      while (frames < f0 + 3 && t < 5000) begin tick(1); t++; end
      tick(100);
      chk("rst_in_frame", 32'(csn), 32'd0);
      rst = 1'b1;
      tick(1);
      chk("rst_mid_csn", 32'(csn), 32'd1);
      chk("rst_mid_valid", 32'(out_valid), 32'd0);
      rst = 1'b0;
      f1 = frames;
      tick(800);
      chk("rst_no_frames", 32'(frames), 32'(f1));
      chk("rst_cmds", 32'(cmd_q.size()), 32'd2);
      clear_q();
      build_exp(8'h03);
      run_pass(8'h03, "rst_restart");
      compare_all("rst_restart");

      // Random masks, data and ready pattern
      rand_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         m = 8'($urandom);
         for (int ch = 0; ch < 8; ch++) dev_val[ch] = 16'($urandom);
         clear_q();
         build_exp(m);
         run_pass(m, "rnd");
         compare_all("rnd");
      end
      rand_ready = 1'b0;
      tick(2);
      out_ready = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

endmodule
